vga_fifo_reader: RTL and testbench

- Read side of the pixel FIFO that the pixel-address writer fills.
- Generates 640x480@60 VGA timing on the pixel clock and pops one 24-bit RGB word per active pixel.
- Drives registered hsync/vsync/blank/RGB to the DAC pins.
- Detects and counts FIFO underflow. No stalling: the VGA raster never waits.

---
 rtl/vga_fifo_reader.sv | 145 ++++++++++++++
 tb/tb_vga_fifo_reader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_fifo_reader.sv
// Pixel-FIFO read side: 640x480@60 raster, one pop per active pixel, registered DAC outputs.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN (adds test_mode input).
module vga_fifo_reader #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fifo_empty,
  input  logic [23:0] fifo_dout,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic        fifo_rd_en,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        underflow,
  output logic [15:0] underflow_cnt,
  output logic        frame_done
);

  localparam logic [9:0] HActive = 10'(H_ACTIVE);
  localparam logic [9:0] VActive = 10'(V_ACTIVE);
  localparam logic [9:0] HsStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VsStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] HLast   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VLast   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic {StPrefill, StRun} state_e;

  state_e      r_state;
  logic [9:0]  r_h, r_v;
  logic        r_s1_active, r_s1_hs, r_s1_vs, r_s1_pop, r_s1_tm;
  logic [23:0] r_s1_pat;
  logic        r_hsync, r_vsync, r_blank;
  logic [23:0] r_rgb;
  logic        r_underflow;
  logic [15:0] r_underflow_cnt;

  logic        w_run, w_active, w_pop, w_miss, w_hs_n, w_vs_n, w_tm;
  logic [23:0] w_pat;

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] w_bar;
  assign w_bar = r_h[9:7];
  assign w_tm  = test_mode;
  assign w_pat = {{8{w_bar[2]}}, {8{w_bar[1]}}, {8{w_bar[0]}}};
`else
  assign w_tm  = 1'b0;
  assign w_pat = 24'h0;
`endif

  assign w_run    = (r_state == StRun);
  assign w_active = w_run & (r_h < HActive) & (r_v < VActive);
  assign w_pop    = w_active & ~fifo_empty & ~w_tm;
  assign w_miss   = w_active & fifo_empty & ~w_tm;
  assign w_hs_n   = ~(w_run & (r_h >= HsStart) & (r_h < HsEnd));
  assign w_vs_n   = ~(w_run & (r_v >= VsStart) & (r_v < VsEnd));

  assign fifo_rd_en = w_pop;
  assign frame_done = w_run & (r_h == HLast) & (r_v == VLast);

  // PREFILL waits for the first data word; RUN free-runs the raster forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StPrefill;
      r_h     <= 10'd0;
      r_v     <= 10'd0;
    end else begin
      unique case (r_state)
        StPrefill: if (!fifo_empty) r_state <= StRun;
        StRun: begin
          if (r_h == HLast) begin
            r_h <= 10'd0;
            r_v <= (r_v == VLast) ? 10'd0 : r_v + 10'd1;
          end else begin
            r_h <= r_h + 10'd1;
          end
        end
        default: r_state <= StPrefill;
      endcase
    end
  end

  // Stage 1 tags the pixel; stage 2 captures FIFO data, which lands one cycle after the pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_active <= 1'b0;
      r_s1_hs     <= 1'b1;
      r_s1_vs     <= 1'b1;
      r_s1_pop    <= 1'b0;
      r_s1_tm     <= 1'b0;
      r_s1_pat    <= 24'h0;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_blank     <= 1'b1;
      r_rgb       <= 24'h0;
    end else begin
      r_s1_active <= w_active;
      r_s1_hs     <= w_hs_n;
      r_s1_vs     <= w_vs_n;
      r_s1_pop    <= w_pop;
      r_s1_tm     <= w_tm & w_active;
      r_s1_pat    <= w_pat;
      r_hsync     <= r_s1_hs;
      r_vsync     <= r_s1_vs;
      r_blank     <= ~r_s1_active;
      if (r_s1_pop)     r_rgb <= fifo_dout;
      else if (r_s1_tm) r_rgb <= r_s1_pat;
      else              r_rgb <= 24'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underflow     <= 1'b0;
      r_underflow_cnt <= 16'h0;
    end else if (w_miss) begin
      r_underflow <= 1'b1;
      if (r_underflow_cnt != 16'hFFFF) r_underflow_cnt <= r_underflow_cnt + 16'd1;
    end
  end

  assign hsync         = r_hsync;
  assign vsync         = r_vsync;
  assign blank         = r_blank;
  assign red           = r_rgb[23:16];
  assign green         = r_rgb[15:8];
  assign blue          = r_rgb[7:0];
  assign underflow     = r_underflow;
  assign underflow_cnt = r_underflow_cnt;

endmodule

// File: tb/tb_vga_fifo_reader.sv
// Scoreboard bench for vga_fifo_reader on a shrunken raster (30x13 clocks) to keep runs short.
module tb_vga_fifo_reader;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty;
  logic [23:0] fifo_dout = 24'h0;
  logic        fifo_rd_en, hsync, vsync, blank, underflow, frame_done;
  logic [7:0]  red, green, blue;
  logic [15:0] underflow_cnt;

  vga_fifo_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .fifo_rd_en(fifo_rd_en), .hsync(hsync), .vsync(vsync), .blank(blank),
    .red(red), .green(green), .blue(blue), .underflow(underflow),
    .underflow_cnt(underflow_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank;
  } exp_t;

  exp_t        exq[$];
  logic [23:0] fq[$];
  logic        r_empty = 1'b1;
  logic        force_empty = 1'b0;
  bit          feed = 0;
  int          feed_n = 0;
  int          cyc = 0, mh = 0, mv = 0, mu_cnt = 0, pops = 0, frames = 0, last_fd = 0;
  bit          mrun = 0;
  int          n_cmp = 0, n_fail = 0;

  assign fifo_empty = r_empty | force_empty;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, req);
    end
  endtask

  // Reference raster model plus FIFO model; expected pixel pushed when its position is scanned.
  always @(posedge clk) begin
    exp_t e;
    bit   act, pop;
    if (rst_n) begin
      act     = mrun && mh < HA && mv < VA;
      pop     = act && !fifo_empty;
      e.due   = cyc + 2;
      e.rgb   = (pop && fq.size() > 0) ? fq[0] : 24'h0;
      e.blank = !act;
      e.hs    = !(mrun && mh >= HA + HF && mh < HA + HF + HS);
      e.vs    = !(mrun && mv >= VA + VF && mv < VA + VF + VS);
      exq.push_back(e);
      if (act && fifo_empty) mu_cnt++;
      if (mrun && mh == HT - 1 && mv == VT - 1) begin
        frames++;
        last_fd = cyc;
      end
      if (mrun) begin
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end else if (!fifo_empty) begin
        mrun = 1;
      end
    end
    if (fifo_rd_en && fq.size() > 0) begin
      pops++;
      fifo_dout <= fq.pop_front();
    end
    r_empty <= (fq.size() == 0);
    cyc++;
  end

  always @(posedge clk) begin
    #2;
    if (feed && fq.size() < 6) begin
      fq.push_back({8'(feed_n), 8'(feed_n + 8'h40), 8'(feed_n + 8'h80)});
      feed_n++;
    end
  end

  // Monitor: every pixel clock out of reset is a DUT output to score.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      while (exq.size() > 0 && exq[0].due < cyc) void'(exq.pop_front());
      if (exq.size() > 0 && exq[0].due == cyc) begin
        e = exq.pop_front();
        check("rgb", {8'h0, red, green, blue}, {8'h0, e.rgb});
        check("blank", blank, e.blank);
        check("hsync", hsync, e.hs);
        check("vsync", vsync, e.vs);
      end
      check("fifo_rd_en", fifo_rd_en, mrun && mh < HA && mv < VA && !fifo_empty);
      check("frame_done", frame_done, mrun && mh == HT - 1 && mv == VT - 1);
      check("underflow_cnt", underflow_cnt, mu_cnt);
      check("underflow", underflow, mu_cnt != 0);
    end
  end

  task automatic wait_pos(input int h, input int v);
    int g = 0;
    while (!(mh == h && mv == v) && g < 2000) begin
      @(posedge clk); #2;
      g++;
    end
    if (g >= 2000) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_pos timeout: got h=%0d v=%0d want h=%0d v=%0d", mh, mv, h, v);
    end
  endtask

  task automatic wait_frames(input int n);
    int g = 0;
    while (frames < n && g < 2000) begin
      @(posedge clk); #2;
      g++;
    end
    if (g >= 2000) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_frames timeout: got %0d want %0d", frames, n);
    end
  endtask

  task automatic force_gap(input int n);
    force_empty = 1'b1;
    repeat (n) @(posedge clk);
    #2 force_empty = 1'b0;
  endtask

  initial begin
    int p1, c1, p3, t0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    check("idle_pops", pops, 0);
    check("idle_state", {hsync, vsync, blank}, 3'b111);

    fq.push_back(24'hA1B2C3);
    fq.push_back(24'h010203);
    feed = 1;

    wait_frames(1);
    check("pops_frame1", pops, HA * VA);
    p1 = pops; c1 = last_fd;
    wait_frames(2);
    check("pops_frame2", pops - p1, HA * VA);
    check("frame_period", last_fd - c1, HT * VT);

    wait_pos(5, 2);
    force_gap(3);
    @(posedge clk); #2;
    check("underflow_cnt_3", underflow_cnt, 3);
    check("underflow_set", underflow, 1);
    wait_pos(HA + 4, 2);
    force_gap(3);
    @(posedge clk); #2;
    check("blank_gap_no_count", underflow_cnt, 3);

    wait_pos(10, 3);
    rst_n = 1'b0;
    #1;
    check("rst_outputs", {hsync, vsync, blank, red, green, blue, fifo_rd_en, frame_done},
          {3'b111, 24'h0, 2'b00});
    check("rst_underflow", {underflow, underflow_cnt}, 17'h0);
    mrun = 0; mh = 0; mv = 0; mu_cnt = 0;
    exq.delete();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    t0 = cyc; p3 = pops;
    wait_frames(3);
    check("restart_pops", pops - p3, HA * VA);
    check("restart_wrap", last_fd - t0, HT * VT);
    repeat (5) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
